// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 2;
  localparam int CMD_W  = OP_W + DATA_W;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_DIV  = 2'b10,
    OP_READ = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } seq_state_e;

  // Queue entry layout: opcode in the top bits, operand below.
  function automatic logic [CMD_W-1:0] pack_cmd(input opcode_e op,
                                                input logic [DATA_W-1:0] data);
    return {op, data};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bundle of command, response and ALU-drive signals around the sequencer.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its payload stable while valid is high and
// ready is low, and valid never depends combinationally on ready.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_data;

  logic [DATA_W-1:0] a_side;
  logic [DATA_W-1:0] b_side;
  logic              pass_add;
  logic              div_pass;
  logic [DATA_W-1:0] alu_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic [DATA_W-1:0] acc;

  // Host side: issues commands, consumes responses, provides the ALU.
  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, alu_out,
    input  cmd_ready, a_side, b_side, pass_add, div_pass,
           rsp_valid, rsp_data, rsp_err, acc
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, alu_out,
    output cmd_ready, a_side, b_side, pass_add, div_pass,
           rsp_valid, rsp_data, rsp_err, acc
  );
endinterface

// File: rtl/alu_sequencer_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter. Head is read
// combinationally so a pop consumes rdata_o on the same edge.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; callers never push when full or pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Queues LOAD/ADD/DIV/READ commands, drives an external ALU for one EXEC
// cycle per command, and returns the resulting accumulator as a response.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output seq_state_e state_dbg_o
);

  seq_state_e        state_q, state_d;
  opcode_e           op_q, op_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic [CMD_W-1:0]  fifo_rdata;
  logic              div_zero;

  assign bus.cmd_ready = !fifo_full && !reset;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  // Divide-by-zero is decided from the operand, independent of the ALU.
  assign div_zero      = (op_q == OP_DIV) && (operand_q == '0);

  cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (pack_cmd(opcode_e'(bus.cmd_op), bus.cmd_data)),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and queue pop decision.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ALU drive during EXEC, response valid during RESP.
  always_comb begin
    bus.a_side    = acc_q;
    bus.b_side    = '0;
    bus.pass_add  = 1'b0;
    bus.div_pass  = 1'b0;
    bus.rsp_valid = (state_q == S_RESP);
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_LOAD: bus.a_side = operand_q;
        OP_ADD: begin
          bus.b_side   = operand_q;
          bus.pass_add = 1'b1;
        end
        OP_DIV: begin
          bus.b_side   = operand_q;
          bus.div_pass = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath next values: latch popped command, capture ALU result in EXEC.
  always_comb begin
    op_d       = op_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (pop) begin
      op_d      = opcode_e'(fifo_rdata[CMD_W-1 -: OP_W]);
      operand_d = fifo_rdata[DATA_W-1:0];
    end
    if (state_q == S_EXEC) begin
      if (div_zero) begin
        rsp_data_d = acc_q;
        rsp_err_d  = 1'b1;
      end else begin
        acc_d      = bus.alu_out;
        rsp_data_d = bus.alu_out;
        rsp_err_d  = 1'b0;
      end
    end
  end

  // Datapath registers; reset clears accumulator and any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_LOAD;
      operand_q  <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      operand_q  <= operand_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.acc      = acc_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a response
// scoreboard fed by hand-computed expectations.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic       clk;
  logic       reset;
  seq_state_e state_dbg;
  alu_seq_if  bus ();

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         got_t[$];
  int         seen_t[$];

  int         add_cnt = 0, div_cnt = 0, both_cnt = 0;
  logic [7:0] add_a, add_b;
  int         add0, div0;

  alu_sequencer #(.CMD_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .state_dbg_o (state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU model; divide by zero yields a junk value on purpose.
  assign bus.alu_out = bus.pass_add ? 8'(bus.a_side + bus.b_side) :
                       bus.div_pass ? ((bus.b_side == 8'd0) ? 8'hFF : 8'(bus.a_side / bus.b_side)) :
                       bus.a_side;

  // Response capture and ALU-select monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      got_q.push_back({bus.rsp_err, bus.rsp_data});
      got_t.push_back(cyc);
    end
    if (bus.pass_add === 1'b1) begin
      add_cnt++;
      add_a = bus.a_side;
      add_b = bus.b_side;
    end
    if (bus.div_pass === 1'b1) div_cnt++;
    if (bus.pass_add === 1'b1 && bus.div_pass === 1'b1) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; holds the command until accepted.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait for all expected responses, then compare in order.
  task automatic check_rsps(input string tag);
    int n = 0;
    logic [8:0] g, e;
    seen_t.delete();
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk({tag, "_timeout"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      seen_t.push_back(got_t.pop_front());
      chk({tag, "_rsp"}, 32'(g), 32'(e));
    end
    exp_q.delete();
    step(3);
    chk({tag, "_extra"}, 32'(got_q.size()), 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'd77;
    bus.rsp_ready = 1'b0;
    reset         = 1'b1;

    // Reset with a command presented: it must be dropped.
    step(3);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_state", state_dbg, S_IDLE);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    chk("post_rst_ready", bus.cmd_ready, 1);
    step(5);
    chk("rst_dropped_rsp", bus.rsp_valid, 0);
    chk("rst_dropped_log", 32'(got_q.size()), 0);

    // LOAD 12 with cycle-exact latency, then ADD 30, READ.
    bus.rsp_ready = 1'b1;
    add0 = add_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_data = 8'd12;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("lat_n0_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    chk("lat_n1_valid", bus.rsp_valid, 0);
    chk("load_exec_a", bus.a_side, 12);
    chk("load_exec_b", bus.b_side, 0);
    chk("load_exec_sel", {bus.pass_add, bus.div_pass}, 0);
    @(posedge clk); #1;
    chk("lat_n2_valid", bus.rsp_valid, 1);
    chk("lat_n2_data", bus.rsp_data, 12);
    send_cmd(2'b01, 8'd30);
    send_cmd(2'b11, 8'd0);
    exp_q.push_back({1'b0, 8'd12});
    exp_q.push_back({1'b0, 8'd42});
    exp_q.push_back({1'b0, 8'd42});
    check_rsps("seq_add_read");
    chk("add_pulse_cnt", 32'(add_cnt - add0), 1);
    chk("add_a_side", add_a, 12);
    chk("add_b_side", add_b, 30);
    chk("acc_42", bus.acc, 42);
    chk("idle_a_side", bus.a_side, 42);
    chk("idle_b_side", bus.b_side, 0);

    // ADD wraps modulo 256.
    send_cmd(2'b00, 8'd200);
    send_cmd(2'b01, 8'd100);
    exp_q.push_back({1'b0, 8'd200});
    exp_q.push_back({1'b0, 8'd44});
    check_rsps("wrap");
    chk("wrap_acc", bus.acc, 44);

    // DIV 7 then DIV 0.
    div0 = div_cnt;
    send_cmd(2'b00, 8'd100);
    send_cmd(2'b10, 8'd7);
    send_cmd(2'b10, 8'd0);
    exp_q.push_back({1'b0, 8'd100});
    exp_q.push_back({1'b0, 8'd14});
    exp_q.push_back({1'b1, 8'd14});
    check_rsps("div");
    chk("div_acc", bus.acc, 14);
    chk("div_pulse_cnt", 32'(div_cnt - div0), 2);

    // Back-pressure: five commands with responses stalled.
    bus.rsp_ready = 1'b0;
    send_cmd(2'b00, 8'd1);
    send_cmd(2'b01, 8'd2);
    send_cmd(2'b01, 8'd3);
    send_cmd(2'b01, 8'd4);
    send_cmd(2'b01, 8'd5);
    step(2);
    chk("full_ready", bus.cmd_ready, 0);
    chk("stall_valid", bus.rsp_valid, 1);
    chk("stall_data", bus.rsp_data, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_data = 8'd99;
    step(3);
    chk("full_ready_hold", bus.cmd_ready, 0);
    chk("stall_data_hold", bus.rsp_data, 1);
    chk("stall_err_hold", bus.rsp_err, 0);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 8'd1});
    exp_q.push_back({1'b0, 8'd3});
    exp_q.push_back({1'b0, 8'd6});
    exp_q.push_back({1'b0, 8'd10});
    exp_q.push_back({1'b0, 8'd15});
    check_rsps("backpressure");

    // Reset while a response is pending and two commands are queued.
    bus.rsp_ready = 1'b0;
    send_cmd(2'b00, 8'd7);
    send_cmd(2'b01, 8'd1);
    send_cmd(2'b01, 8'd2);
    step(3);
    chk("pre_rst_valid", bus.rsp_valid, 1);
    chk("pre_rst_data", bus.rsp_data, 7);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", bus.cmd_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst2_valid", bus.rsp_valid, 0);
    chk("rst2_acc", bus.acc, 0);
    chk("rst2_rsp_data", bus.rsp_data, 0);
    chk("rst2_ready", bus.cmd_ready, 1);
    step(4);
    chk("rst2_queue_empty", bus.rsp_valid, 0);
    chk("rst2_state", state_dbg, S_IDLE);
    bus.rsp_ready = 1'b1;
    chk("rst2_log", 32'(got_q.size()), 0);
    send_cmd(2'b11, 8'd0);
    exp_q.push_back({1'b0, 8'd0});
    check_rsps("rst2_read");

    // Back-to-back ADD 1 x8 after LOAD 0: one response every two cycles.
    send_cmd(2'b00, 8'd0);
    for (int i = 0; i < 8; i++) send_cmd(2'b01, 8'd1);
    exp_q.push_back({1'b0, 8'd0});
    for (int i = 1; i <= 8; i++) exp_q.push_back({1'b0, 8'(i)});
    check_rsps("b2b");
    for (int i = 1; i < seen_t.size(); i++)
      chk("b2b_spacing", 32'(seen_t[i] - seen_t[i-1]), 2);
    chk("b2b_acc", bus.acc, 8);

    chk("sel_exclusive", 32'(both_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: CMD_DEPTH, default 4, command queue depth; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  queue can accept a command.
REQ-006 cmd_op  input  2  opcode: 00 LOAD, 01 ADD, 10 DIV, 11 READ.
REQ-007 cmd_data  input  8  operand.
REQ-008 a_side  output  8  ALU A operand.
REQ-009 b_side  output  8  ALU B operand.
REQ-010 pass_add  output  1  ALU add select.
REQ-011 div_pass  output  1  ALU divide select.
REQ-012 alu_out  input  8  ALU result (combinational from a_side/b_side/selects).
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  response consumed.
REQ-015 rsp_data  output  8  accumulator value after the command.
REQ-016 rsp_err  output  1  divide-by-zero flag for this response.
REQ-017 acc  output  8  current accumulator.

Function
REQ-018 Command is accepted on an edge with cmd_valid && cmd_ready and written into the FIFO queue; cmd_ready = !full && !reset.
REQ-019 No bypass: a command accepted into an empty queue is popped no earlier than the following edge; a full queue refuses (cmd_ready=0), so full-queue push+pop never coincides.
REQ-020 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-021 IDLE: if queue non-empty, pop head into op/operand registers, go to EXEC; else stay.
REQ-022 EXEC (exactly one cycle): drive ALU from the latched op; on the edge, capture result into acc and rsp_data, set rsp_err, go to RESP.
REQ-023 ALU drive in EXEC: LOAD a=operand,b=0,selects 0; ADD a=acc,b=operand,pass_add=1; DIV a=acc,b=operand,div_pass=1; READ a=acc,b=0,selects 0.
REQ-024 Outside EXEC: a_side=acc, b_side=0, pass_add=0, div_pass=0; pass_add and div_pass never both 1.
REQ-025 ADD wraps modulo 256, no carry reported; DIV is unsigned integer quotient.
REQ-026 DIV with operand 0: acc unchanged, rsp_data=old acc, rsp_err=1; sequencer checks operand itself, never uses ALU zero result.
REQ-027 rsp_err=0 for all other commands.
REQ-028 RESP: rsp_valid=1, rsp_data/rsp_err held stable until the edge with rsp_ready=1.
REQ-029 RESP with rsp_ready: if queue non-empty pop head and go to EXEC directly, else go to IDLE.
REQ-030 Minimum latency: accept at edge N, rsp_valid high after edge N+2; sustained throughput one command per 2 cycles with rsp_ready tied high.
REQ-031 Responses are returned in command order, exactly one per command.

Reset
REQ-032 Reset asserted at an edge: state=IDLE, queue emptied, acc=0, rsp_data=0, rsp_err=0, rsp_valid=0; in-flight command and pending response discarded.
REQ-033 cmd_ready=0 while reset high; commands presented during reset are dropped.

Structure
REQ-034 Shared package alu_seq_pkg holds DATA_W=8, opcode enum (OP_LOAD, OP_ADD, OP_DIV, OP_READ), and state enum.
REQ-035 One sub-module cmd_fifo (synchronous FIFO, CMD_DEPTH x 10 bits, full/empty, pointer wrap with extra bit).
REQ-036 ALU is instantiated by the parent, not inside alu_sequencer.

Verification
REQ-037 LOAD 12, ADD 30, READ with rsp_ready=1 -> responses 12, 42, 42, all rsp_err=0; pass_add high only in the ADD EXEC cycle.
REQ-038 LOAD 200, ADD 100 -> response 44 (wrap), rsp_err=0.
REQ-039 LOAD 100, DIV 7, DIV 0 -> responses 14, 14 with rsp_err=0 then 1; acc stays 14.
REQ-040 rsp_ready=0, push 5 commands with CMD_DEPTH=4 -> cmd_ready drops after queue fills; release rsp_ready -> all accepted commands answered in order, none lost.
REQ-041 Reset asserted during RESP with 2 queued commands -> next cycle rsp_valid=0, acc=0, queue empty; subsequent READ returns 0.
REQ-042 Back-to-back ADD 1 x8 after LOAD 0 with rsp_ready=1 -> responses 1..8, rsp_valid every second cycle.
